// File: rtl/hacd_pkg.sv
// Shared types and constants for the hawk compress/decompress path.
package hacd_pkg;

    localparam int CMP_PAGE_LINES = 64;
    localparam int LINE_BYTES     = 64;
    localparam int PAGE_SHIFT     = 12;

    // comp_decomp=1 selects compress (read a whole 4 KiB page by iWay_ptr).
    typedef struct packed {
        logic        comp_decomp;
        logic [35:0] iWay_ptr;
        logic [47:0] cPage_byteStart;
    } iWayORcPagePkt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_TRIGGER,
        ST_WAIT_DONE,
        ST_RESP
    } cmpdcmp_rd_state_t;

endpackage

// File: rtl/hawk_rd_issue_ctr.sv
// Read-issue bookkeeping: issue/response counters, outstanding limit and line address generation.
module hawk_rd_issue_ctr
    import hacd_pkg::*;
#(
    parameter int ADDR_W          = 48,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [6:0]        total_i,
    input  logic              active_i,
    input  logic              rd_req_ready,
    input  logic              rd_resp_valid,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    output logic              last_rsp_o
);

    logic [6:0]        iss_cnt_q, iss_cnt_d;
    logic [6:0]        rsp_cnt_q, rsp_cnt_d;
    logic [6:0]        total_q, total_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [6:0]        outstanding;
    logic              issue;
    logic              resp;

    // Counters are 7 bits so a full page (64) is representable; the difference never exceeds 64.
    assign outstanding  = iss_cnt_q - rsp_cnt_q;
    assign rd_req_valid = active_i && (iss_cnt_q < total_q)
                          && ({1'b0, outstanding} < 8'(MAX_OUTSTANDING));
    assign issue        = rd_req_valid && rd_req_ready;
    assign resp         = active_i && rd_resp_valid;
    assign rd_req_addr  = active_i ? base_q + (ADDR_W'(iss_cnt_q) << $clog2(LINE_BYTES)) : '0;
    assign last_rsp_o   = resp && (rsp_cnt_d == total_q);

    always_comb begin
        iss_cnt_d = iss_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        total_d   = total_q;
        base_d    = base_q;
        if (start_i) begin
            iss_cnt_d = '0;
            rsp_cnt_d = '0;
            total_d   = total_i;
            base_d    = base_i;
        end else begin
            if (issue) iss_cnt_d = iss_cnt_q + 7'd1;
            if (resp)  rsp_cnt_d = rsp_cnt_q + 7'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iss_cnt_q <= '0;
            rsp_cnt_q <= '0;
            total_q   <= '0;
            base_q    <= '0;
        end else begin
            iss_cnt_q <= iss_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            total_q   <= total_d;
            base_q    <= base_d;
        end
    end

endmodule

// File: rtl/hawk_cmpdcmp_rd_mngr.sv
// Read manager for one page-migration request: reads source lines, triggers the write manager, reports done.
// Optional HAWK_CMPDCMP_RD_CHKSUM_EN adds rd_chksum, the XOR of all response lines of the current request.
module hawk_cmpdcmp_rd_mngr
    import hacd_pkg::*;
#(
    parameter int ADDR_W          = 48,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid,
    output logic              req_ready,
    input  iWayORcPagePkt_t   req_pkt,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_req_ready,
    input  logic              rd_resp_valid,
    input  logic [511:0]      rd_resp_data,
    output logic              cmpdcmp_trigger,
    output iWayORcPagePkt_t   iWayORcPagePkt,
    input  logic              cmpdcmp_done,
    output logic              req_done,
    output logic              busy
`ifdef HAWK_CMPDCMP_RD_CHKSUM_EN
    ,
    output logic [511:0]      rd_chksum
`endif
);

    cmpdcmp_rd_state_t state_q, state_d;
    iWayORcPagePkt_t   pkt_q, pkt_d;
    logic              accept;
    logic              last_rsp;
    logic [ADDR_W-1:0] base_addr;
    logic [6:0]        total;

    // Compress reads the whole page behind iWay_ptr; decompress reads the one line holding cPage_byteStart.
    assign base_addr = req_pkt.comp_decomp
                       ? (ADDR_W'(req_pkt.iWay_ptr) << PAGE_SHIFT)
                       : (ADDR_W'(req_pkt.cPage_byteStart) & ~ADDR_W'(LINE_BYTES - 1));
    assign total     = req_pkt.comp_decomp ? 7'(CMP_PAGE_LINES) : 7'd1;

    hawk_rd_issue_ctr #(
        .ADDR_W          (ADDR_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_ctr (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (accept),
        .base_i        (base_addr),
        .total_i       (total),
        .active_i      (state_q == ST_READ),
        .rd_req_ready  (rd_req_ready),
        .rd_resp_valid (rd_resp_valid),
        .rd_req_valid  (rd_req_valid),
        .rd_req_addr   (rd_req_addr),
        .last_rsp_o    (last_rsp)
    );

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    pkt_d   = req_pkt;
                    state_d = ST_READ;
                end
            end
            ST_READ:      if (last_rsp) state_d = ST_TRIGGER;
            ST_TRIGGER:   state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (cmpdcmp_done) state_d = ST_RESP;
            ST_RESP:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
        end
    end

    assign req_ready       = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign cmpdcmp_trigger = (state_q == ST_TRIGGER);
    assign req_done        = (state_q == ST_RESP);
    assign iWayORcPagePkt  = pkt_q;

`ifdef HAWK_CMPDCMP_RD_CHKSUM_EN
    logic [511:0] chksum_q, chksum_d;

    always_comb begin
        chksum_d = chksum_q;
        if (accept)
            chksum_d = '0;
        else if ((state_q == ST_READ) && rd_resp_valid)
            chksum_d = chksum_q ^ rd_resp_data;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) chksum_q <= '0;
        else         chksum_q <= chksum_d;
    end

    assign rd_chksum = chksum_q;
`else
    // Line data goes straight to the compressor core; nothing here consumes it.
    logic unused_resp_data;
    assign unused_resp_data = ^rd_resp_data;
`endif

endmodule

// File: doc/hawk_cmpdcmp_rd_mngr.md
# hawk_cmpdcmp_rd_mngr

Upstream sequencer for the compress/decompress path. It accepts one page-migration request, reads the source data over the internal AXI read channel, then hands the latched `iWayORcPagePkt_t` to the write manager via a single-cycle `cmpdcmp_trigger`. When the write manager returns `cmpdcmp_done`, this block signals completion to the requester. Only one request is in flight at a time.

## Interface
**Parameters**
- `ADDR_W`, 48: byte-address width of AXI read requests.
- `MAX_OUTSTANDING`, 8: maximum read requests issued but not yet answered (power of 2, range 1..64).

**Ports**
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset; asynchronous assert, active-low.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  high only in IDLE.
- `req_pkt`  in  `iWayORcPagePkt_t`  request descriptor; `comp_decomp`=1 means compress.
- `rd_req_valid`  out  1  AXI read request valid.
- `rd_req_addr`  out  `ADDR_W`  64B-aligned line address.
- `rd_req_ready`  in  1  read engine accepts the request.
- `rd_resp_valid`  in  1  one 64B line returned; responses arrive in order.
- `rd_resp_data`  in  512  returned line data.
- `cmpdcmp_trigger`  out  1  one-cycle pulse to the write manager.
- `iWayORcPagePkt`  out  `iWayORcPagePkt_t`  latched request; stable from trigger until done.
- `cmpdcmp_done`  in  1  write-manager completion pulse.
- `req_done`  out  1  one-cycle completion pulse to the requester.
- `busy`  out  1  asserted in any state other than IDLE.

## Operation
- **IDLE**
  - A request is accepted when `req_valid & req_ready`.
  - On acceptance, latch `req_pkt`, clear the issue and response counters, and go to READ.
  - Set `total` from the request type:
    - Compress: 64 lines, starting at `{iWay_ptr, 12'h000}`, zero-extended to `ADDR_W`.
    - Decompress: 1 line, at `{cPage_byteStart[ADDR_W-1:6], 6'b0}`.
- **READ**
  - `rd_req_valid` = `(iss_cnt < total) & ((iss_cnt - rsp_cnt) < MAX_OUTSTANDING)`.
  - `rd_req_addr` = `base + iss_cnt*64`.
  - `iss_cnt` increments on `rd_req_valid & rd_req_ready`.
  - `rsp_cnt` increments on each `rd_resp_valid`.
  - Counters are 7 bits wide so that the value 64 is representable.
  - Go to TRIGGER when `rsp_cnt` reaches `total`. This includes the cycle in which the last response arrives: the next state is TRIGGER.
  - Read data is not buffered here; the compressor core samples the `rd_resp_*` bus directly.
- **TRIGGER**
  - Assert `cmpdcmp_trigger` for exactly one cycle, then go to WAIT_DONE.
- **WAIT_DONE**
  - Hold `iWayORcPagePkt`.
  - On `cmpdcmp_done`, go to RESP.
- **RESP**
  - Pulse `req_done` for one cycle, then go to IDLE.
- Stray inputs:
  - A `rd_resp_valid` outside READ is ignored and does not change the counters.
  - A `cmpdcmp_done` outside WAIT_DONE is ignored.
- Request and response in the same cycle: issue and response may coincide. Both counters update in that cycle, and the outstanding count is unchanged.

## Timing
- Reset values of all outputs:
  - `req_ready`=1 and `busy`=0.
  - `rd_req_valid`, `cmpdcmp_trigger` and `req_done` are 0.
  - `rd_req_addr` and `iWayORcPagePkt` are 0.
  - State is IDLE.
- Reset asserted mid-operation returns the block to IDLE immediately. The in-flight request is dropped, no `req_done` is produced, and late responses are ignored.
- The first read request is visible the cycle after acceptance.
- With `rd_req_ready` tied high, the issue rate is one request per cycle. With a zero-latency read engine, the minimum latency from acceptance to trigger is `total`+1 cycles.
- `cmpdcmp_trigger` fires the cycle after the final response.
- `req_done` fires the cycle after `cmpdcmp_done`.
- `rd_req_valid` and `rd_req_addr` are held stable until `rd_req_ready` is seen (AXI-style hold).

## Configuration
- `HAWK_CMPDCMP_RD_CHKSUM_EN`
  - **Defined:** add output `rd_chksum` [511:0], an XOR of every response line for the current request. It is cleared when a request is accepted and is stable from TRIGGER until the next acceptance. This is a debug/verification aid.
  - **Undefined:** the port and its logic are absent, and behaviour is otherwise identical.

## Structure
- Put the following in `hacd_pkg`:
  - the state enum `cmpdcmp_rd_state_t`;
  - constants `CMP_PAGE_LINES=64`, `LINE_BYTES=64`, `PAGE_SHIFT=12`.
- `iWayORcPagePkt_t` already lives in `hacd_pkg` and is reused unchanged.
- One sub-module is natural: `hawk_rd_issue_ctr`, which holds the issue/response counters, the outstanding-limit compare and the address generation. The FSM stays in the top module.
- Integration: instantiate directly upstream of `hawk_cmpdcmp_wr_mngr`, sharing `cmpdcmp_trigger`, `iWayORcPagePkt` and `cmpdcmp_done`.

## Test plan
- **Compress, no backpressure:** `iWay_ptr`=0x5, `comp_decomp`=1, `rd_req_ready`=1, responses returned 2 cycles after each request.
  - Expect addresses 0x5000..0x5FC0 in steps of 0x40 (64 requests).
  - Expect one trigger after the 64th response, then `req_done` one cycle after `cmpdcmp_done`.
- **Decompress:** `cPage_byteStart`=0x1234_5678.
  - Expect a single request at 0x1234_5640, then the trigger.
- **Outstanding limit:** `MAX_OUTSTANDING`=8, responses withheld.
  - Expect exactly 8 requests, then `rd_req_valid`=0.
  - Release one response: expect exactly one more request.
- **Backpressure:** `rd_req_ready` toggles randomly.
  - Expect address and valid held stable while stalled, and no skipped or duplicated address.
- **Reset and stray inputs:**
  - Assert `rst_ni`=0 at `iss_cnt`=30: expect all outputs at their reset values and no `req_done`.
  - After reset, a stray `rd_resp_valid` leaves the counters at 0.
  - A stray `cmpdcmp_done` in IDLE produces no effect.
- **`HAWK_CMPDCMP_RD_CHKSUM_EN` defined:**
  - 64 lines with alternating data 0xA…A / 0x5…5: expect `rd_chksum`=0.
  - A single line 0xF0F0…: expect `rd_chksum` equal to that line.
